// File: rtl/main_control_pkg.sv
// Shared definitions for the multicycle main control FSM: states, opcodes, mux codes
// and the per-state output decode.
package main_control_pkg;

  typedef enum logic [4:0] {
    StRst, StFetch, StFetchWait, StIrLoad, StDecode, StMemAddr, StMemRead, StMemWait,
    StMemWb, StMemWrite, StRExec, StRWb, StAddiExec, StAddiWb, StBranch, StJump, StHalt
  } state_e;

  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpJ     = 6'h02;

  localparam logic [2:0] AluAdd   = 3'b000;
  localparam logic [2:0] AluSub   = 3'b001;
  localparam logic [2:0] AluFunct = 3'b010;

  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  localparam logic [1:0] PcAlu    = 2'b00;
  localparam logic [1:0] PcAluOut = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       halted;
  } ctrl_t;

  // Branch PCWrite is excluded here; it depends on Zero and is merged in the top.
  function automatic ctrl_t ctrl_decode(input state_e st);
    ctrl_t c;
    c = '0;
    case (st)
      StFetch: c.mem_read = 1'b1;
      StFetchWait, StMemWait: c.mem_read = 1'b1;
      StIrLoad: begin
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = SrcBFour;
        c.alu_op    = AluAdd;
        c.pc_source = PcAlu;
      end
      StDecode: c.alu_src_b = SrcBImmSh;
      StMemAddr, StAddiExec: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SrcBImm;
        c.alu_op    = AluAdd;
      end
      StMemRead: begin
        c.iord     = 1'b1;
        c.mem_read = 1'b1;
      end
      StMemWb: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      StMemWrite: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      StRExec: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SrcBReg;
        c.alu_op    = AluFunct;
      end
      StRWb: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      StAddiWb: c.reg_write = 1'b1;
      StBranch: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SrcBReg;
        c.alu_op    = AluSub;
        c.pc_source = PcAluOut;
      end
      StJump: begin
        c.pc_source = PcJump;
        c.pc_write  = 1'b1;
      end
      StHalt: c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/main_control.sv
// Multicycle MIPS-style main control FSM with a configurable memory-wait counter.
// Optional bne support is enabled by defining MAIN_CONTROL_BNE_EN.
module main_control
  import main_control_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       Break,
  input  logic       Zero,
  output logic [2:0] ALUOp,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       Halted
);

  localparam logic [2:0] WaitInit = 3'(MEM_WAIT);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  ctrl_t      ctrl_q;
  logic       branch_taken;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StRst: state_d = StFetch;
      StFetch: begin
        cnt_d   = WaitInit;
        state_d = (WaitInit == 3'd0) ? StIrLoad : StFetchWait;
      end
      // Counter stops at 1 so it never wraps.
      StFetchWait: begin
        if (cnt_q <= 3'd1) state_d = StIrLoad;
        else               cnt_d   = cnt_q - 3'd1;
      end
      StIrLoad: state_d = StDecode;
      StDecode: begin
        case (Opcode)
          OpRType:    state_d = Break ? StHalt : StRExec;
          OpLw, OpSw: state_d = StMemAddr;
          OpAddi:     state_d = StAddiExec;
          OpBeq:      state_d = StBranch;
`ifdef MAIN_CONTROL_BNE_EN
          OpBne:      state_d = StBranch;
`endif
          OpJ:        state_d = StJump;
          default:    state_d = StFetch;
        endcase
      end
      StMemAddr: begin
        if (Opcode == OpLw)      state_d = StMemRead;
        else if (Opcode == OpSw) state_d = StMemWrite;
        else                     state_d = StFetch;
      end
      StMemRead: begin
        cnt_d   = WaitInit;
        state_d = (WaitInit == 3'd0) ? StMemWb : StMemWait;
      end
      StMemWait: begin
        if (cnt_q <= 3'd1) state_d = StMemWb;
        else               cnt_d   = cnt_q - 3'd1;
      end
      StRExec:    state_d = StRWb;
      StAddiExec: state_d = StAddiWb;
      StHalt:     state_d = StHalt;
      StMemWb, StMemWrite, StRWb, StAddiWb, StBranch, StJump: state_d = StFetch;
      default:    state_d = StRst;
    endcase
  end

`ifdef MAIN_CONTROL_BNE_EN
  logic bne_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRst;
      cnt_q   <= 3'd0;
      ctrl_q  <= '0;
`ifdef MAIN_CONTROL_BNE_EN
      bne_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_decode(state_d);
`ifdef MAIN_CONTROL_BNE_EN
      if (state_q == StDecode) bne_q <= (Opcode == OpBne);
`endif
    end
  end

`ifdef MAIN_CONTROL_BNE_EN
  assign branch_taken = Zero ^ bne_q;
`else
  assign branch_taken = Zero;
`endif

  assign PCWrite  = ctrl_q.pc_write | ((state_q == StBranch) & branch_taken);
  assign IorD     = ctrl_q.iord;
  assign MemRead  = ctrl_q.mem_read;
  assign MemWrite = ctrl_q.mem_write;
  assign IRWrite  = ctrl_q.ir_write;
  assign RegDst   = ctrl_q.reg_dst;
  assign MemtoReg = ctrl_q.mem_to_reg;
  assign RegWrite = ctrl_q.reg_write;
  assign ALUSrcA  = ctrl_q.alu_src_a;
  assign ALUSrcB  = ctrl_q.alu_src_b;
  assign PCSource = ctrl_q.pc_source;
  assign ALUOp    = ctrl_q.alu_op;
  assign Halted   = ctrl_q.halted;

endmodule

// File: doc/main_control.md
MAIN_CONTROL -- requirements
Module: main_control

Interface
REQ-001 Parameter MEM_WAIT, default 1: number of extra memory-wait cycles (0..7) after every memory read.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 Opcode  in  6  instruction register bits [31:26].
REQ-005 Break  in  1  break flag from ALU control (Funct==0x0d).
REQ-006 Zero  in  1  ALU zero flag.
REQ-007 ALUOp  out  3  000 add, 001 sub, 010 funct-defined.
REQ-008 PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA  out  1 each  datapath strobes/selects.
REQ-009 ALUSrcB  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-010 PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-011 Halted  out  1  high while in HALT.

Function
REQ-012 Moore FSM; outputs decoded from state only, except PCWrite in BRANCH (depends on Zero).
REQ-013 States: RST, FETCH, FETCH_WAIT, IR_LOAD, DECODE, MEM_ADDR, MEM_READ, MEM_WAIT, MEM_WB, MEM_WRITE, R_EXEC, R_WB, ADDI_EXEC, ADDI_WB, BRANCH, JUMP, HALT.
REQ-014 Any output not listed for a state is 0.
REQ-015 RST: all outputs 0; next FETCH.
REQ-016 FETCH: IorD=0, MemRead=1; loads wait counter with MEM_WAIT; next FETCH_WAIT, or IR_LOAD if MEM_WAIT=0.
REQ-017 FETCH_WAIT / MEM_WAIT: MemRead=1, counter decrements; exit when counter reaches 1 (FETCH_WAIT->IR_LOAD, MEM_WAIT->MEM_WB).
REQ-018 IR_LOAD: IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00; next DECODE.
REQ-019 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000.
REQ-020 DECODE dispatch on Opcode: 0x00 -> HALT if Break else R_EXEC; 0x23/0x2b -> MEM_ADDR; 0x08 -> ADDI_EXEC; 0x04 -> BRANCH; 0x02 -> JUMP; any other -> FETCH (NOP).
REQ-021 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=000; next MEM_READ (0x23) or MEM_WRITE (0x2b).
REQ-022 MEM_READ: IorD=1, MemRead=1, loads counter; next MEM_WAIT, or MEM_WB if MEM_WAIT=0.
REQ-023 MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1; next FETCH.
REQ-024 MEM_WRITE: IorD=1, MemWrite=1; next FETCH.
REQ-025 R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=010; next R_WB. R_WB: RegDst=1, MemtoReg=0, RegWrite=1; next FETCH.
REQ-026 ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=000; next ADDI_WB. ADDI_WB: RegDst=0, MemtoReg=0, RegWrite=1; next FETCH.
REQ-027 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01, PCWrite=Zero (beq); next FETCH.
REQ-028 JUMP: PCSource=10, PCWrite=1; next FETCH.
REQ-029 HALT: Halted=1, all strobes 0; remains until reset.
REQ-030 MemRead and MemWrite are never both 1; wait counter is 3 bits, never wraps below 1.

Reset
REQ-031 reset sampled high at any edge, in any state (including mid-wait), forces RST and counter 0 on that edge; all outputs 0 the following cycle.
REQ-032 First FETCH occurs two cycles after reset is released.

Configuration
REQ-033 Macro MAIN_CONTROL_BNE_EN defined: Opcode 0x05 -> BRANCH with PCWrite=~Zero; branch sense held in a registered flag set in DECODE.
REQ-034 Macro undefined: 0x05 is treated as an unknown opcode (-> FETCH), no flag register.

Structure
REQ-035 Shared package holds state enum, opcode constants, ALUOp codes, ALUSrcB/PCSource codes.
REQ-036 No sub-module; single FSM plus wait counter.

Verification
REQ-037 reset high 3 cycles, release -> all outputs 0, FETCH (MemRead=1) at 2nd cycle after release.
REQ-038 MEM_WAIT=2, Opcode 0x23 -> FETCH,2xFETCH_WAIT,IR_LOAD,DECODE,MEM_ADDR,MEM_READ,2xMEM_WAIT,MEM_WB (RegWrite=1, MemtoReg=1).
REQ-039 Opcode 0x00, Break=0 -> R_EXEC ALUOp=010, R_WB RegDst=1 RegWrite=1; Break=1 -> HALT, Halted=1 held 10 cycles.
REQ-040 Opcode 0x04: Zero=1 -> PCWrite=1 PCSource=01; Zero=0 -> PCWrite=0; with BNE_EN, 0x05 gives inverse.
REQ-041 reset asserted during MEM_WAIT -> RST next cycle, MemRead=0; Opcode 0x3f -> DECODE then FETCH, no RegWrite/MemWrite.
